// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time, fixed WAIT_STATES+1 cycle latency.
// req_ready is high only when idle; requests presented while busy are held off until the next idle cycle.
module mem_responder #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [15:0]       txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [15:0]       txn_q;

    logic              accept;
    logic              enter_resp;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_M1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge itself, so bypass the latches.
    assign enter_resp = (state_d == ST_RESP);
    assign acc_wr     = (state_q == ST_IDLE) ? req_write : wr_q;
    assign acc_addr   = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata  = (state_q == ST_IDLE) ? req_wdata : wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            txn_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= acc_wr ? '0 : mem[acc_addr];
            end
            if (state_q == ST_RESP) begin
                txn_q <= txn_q + 16'd1;
            end
        end
    end

    // Storage is deliberately outside the reset domain; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && acc_wr) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: WAIT_STATES=2 instance for latency/hold/reset cases, WAIT_STATES=0 instance for back-to-back traffic.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid, req_write;
    logic [12:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready, rsp_valid, busy;
    logic [15:0] rsp_rdata, txn_count;

    logic        req_valid0, req_write0;
    logic [12:0] req_addr0;
    logic [15:0] req_wdata0;
    logic        req_ready0, rsp_valid0, busy0;
    logic [15:0] rsp_rdata0, txn_count0;

    int checks   = 0;
    int failures = 0;
    int err_lat0 = 0;
    int err_rd0  = 0;

    typedef struct {
        logic        w;
        logic [12:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    mem_responder #(.ADDR_W(13), .DATA_W(16), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .txn_count(txn_count)
    );

    mem_responder #(.ADDR_W(13), .DATA_W(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .busy(busy0), .txn_count(txn_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge with the WAIT_STATES=2 instance idle; returns at a falling edge, idle again.
    task automatic txn(input vec_t v, input string nm);
        int pulses = 0;
        int at_k   = 0;
        logic [15:0] rd = 16'h0;
        req_valid = 1'b1;
        req_write = v.w;
        req_addr  = v.a;
        req_wdata = v.d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~v.w;
        req_addr  = v.a ^ 13'h0aa;
        req_wdata = ~v.d;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                at_k = k;
                rd   = rsp_rdata;
            end
        end
        check({nm, "_pulses"}, pulses, 1);
        check({nm, "_latency"}, at_k, 3);
        check({nm, "_rdata"}, rd, v.exp);
    endtask

    task automatic abort_write(input logic [12:0] a, input logic [15:0] d, input int krst, input string nm);
        int pulses = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= krst; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_ready"}, req_ready, 1);
        check({nm, "_txn"}, txn_count, 0);
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        check({nm, "_no_rsp"}, pulses, 0);
    endtask

    // WAIT_STATES=0 instance: called at a falling edge while idle, spends exactly two cycles.
    task automatic txn0(input logic w, input logic [12:0] a, input logic [15:0] d, input logic [15:0] exp);
        req_valid0 = 1'b1;
        req_write0 = w;
        req_addr0  = a;
        req_wdata0 = d;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        @(negedge clk);
        if (!rsp_valid0) err_lat0++;
        if (rsp_rdata0 !== exp) err_rd0++;
        @(negedge clk);
        if (rsp_valid0 || !req_ready0) err_lat0++;
    endtask

    initial begin
        vecs[0] = '{1'b1, 13'h0010, 16'h0005, 16'h0000};
        vecs[1] = '{1'b0, 13'h0010, 16'h0000, 16'h0005};
        vecs[2] = '{1'b1, 13'h1FFF, 16'hA5A5, 16'h0000};
        vecs[3] = '{1'b1, 13'h0000, 16'h5A5A, 16'h0000};
        vecs[4] = '{1'b0, 13'h1FFF, 16'h0000, 16'hA5A5};
        vecs[5] = '{1'b0, 13'h0000, 16'h0000, 16'h5A5A};
        vecs[6] = '{1'b1, 13'h0020, 16'h1234, 16'h0000};
        vecs[7] = '{1'b0, 13'h0020, 16'h0000, 16'h1234};
        vecs[8] = '{1'b1, 13'h0010, 16'hFFFF, 16'h0000};
        vecs[9] = '{1'b0, 13'h0010, 16'h0000, 16'hFFFF};

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_txn", txn_count, 0);

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i], $sformatf("vec%0d", i));
            check($sformatf("vec%0d_txn", i), txn_count, i + 1);
        end

        // Held valid: A accepted now, B held through the busy window and accepted in the first idle cycle.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h0010; req_wdata = 16'h0;
        @(posedge clk);
        #1;
        req_addr = 13'h1FFF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("hold_k%0d_rsp_valid", k), rsp_valid, (k == 3 || k == 7) ? 1 : 0);
            check($sformatf("hold_k%0d_busy", k), busy, (k == 4 || k == 8) ? 0 : 1);
            if (k == 3) check("hold_A_rdata", rsp_rdata, 16'hFFFF);
            if (k == 7) check("hold_B_rdata", rsp_rdata, 16'hA5A5);
            if (k == 4) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        check("hold_txn", txn_count, 12);

        abort_write(13'h0020, 16'hBEEF, 1, "abort_wait");
        txn('{1'b0, 13'h0020, 16'h0, 16'h1234}, "abort_wait_read");
        abort_write(13'h0020, 16'hDEAD, 2, "abort_commit");
        txn('{1'b0, 13'h0020, 16'h0, 16'h1234}, "abort_commit_read");

        // Reset and a request on the same edge: nothing may be accepted.
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h0020; req_wdata = 16'h7777;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_vs_req_busy", busy, 0);
        check("rst_vs_req_ready", req_ready, 1);
        txn('{1'b0, 13'h0020, 16'h0, 16'h1234}, "rst_vs_req_read");

        for (int j = 0; j < 200; j++)
            txn0(1'b1, 13'(j * 41), 16'(j) ^ 16'h5A3C, 16'h0000);
        for (int j = 0; j < 200; j++)
            txn0(1'b0, 13'(j * 41), 16'h0000, 16'(j) ^ 16'h5A3C);
        check("ws0_latency_spacing_errors", err_lat0, 0);
        check("ws0_rdata_errors", err_rd0, 0);
        check("ws0_txn", txn_count0, 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
